// File: rtl/pe_feeder_pkg.sv
// Shared types and helpers for the PE array skew feeder.
// Latency: n/a (types only).
// Backpressure: n/a.
package pe_feeder_pkg;

  // Issue control FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

  // Width of a counter able to hold values up to num_lanes-1 (never below 1 bit).
  function automatic int lane_idx_w(input int num_lanes);
    return (num_lanes > 2) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/pe_feeder_fifo.sv
// Synchronous FIFO holding whole operand vectors for the skew feeder.
// Latency: a pushed word is visible on pop_data the cycle after the push edge.
// Backpressure: full/empty come from a registered count; a push when full or a pop when empty is ignored.
// Ports: clk, rst (sync, active high), push/push_data, pop/pop_data, full, empty.
module pe_feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit and wrap by natural overflow.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pe_skew_feeder.sv
// Buffers operand vectors and issues them into the PE array with lane i delayed i cycles.
// Latency: pop to lane i out_ena is i+1 advance (non-stall) cycles.
// Backpressure: in_ready = !fifo_full; stall freezes issue and skew, forcing out_ena/out_last low.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data/in_last vector input;
//        stall; out_data/out_ena/out_last per-lane array feed; busy.
module pe_skew_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  input  logic                            in_last,
  input  logic                            stall,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_ena,
  output logic                            out_last,
  output logic                            busy
);

  localparam int VW = NUM_LANES * DATA_WIDTH;
  localparam int CW = lane_idx_w(NUM_LANES);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(NUM_LANES - 1);

  logic          fifo_full;
  logic          fifo_empty;
  logic [VW:0]   fifo_dout;
  logic          advance;
  logic          pop;
  feeder_state_t state;
  logic [CW-1:0] drain_cnt;

  // Slot issued into skew stage 0 this cycle.
  logic          slot_valid;
  logic          slot_last;
  logic [VW-1:0] slot_data;

  assign in_ready = !fifo_full;
  assign advance  = !stall;
  // DRAIN never pops, so next-tile data waits until the previous tile has cleared every lane.
  assign pop        = advance && !fifo_empty && (state != DRAIN);
  assign slot_valid = pop;
  assign slot_last  = pop && fifo_dout[VW];
  assign slot_data  = pop ? fifo_dout[VW-1:0] : '0;

  pe_feeder_fifo #(
    .WIDTH (VW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid && in_ready),
    .push_data ({in_last, in_data}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue FSM. The drain counter gives NUM_LANES-1 bubbles after a tile's last pop,
  // so the next tile's lane 0 starts only after the last tile's final lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else if (advance) begin
      case (state)
        IDLE, STREAM: begin
          if (pop) begin
            if (slot_last) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == CW'(1)) state <= fifo_empty ? IDLE : STREAM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shared valid/last delay chain; stage k holds the slot issued k+1 advances ago.
  logic [NUM_LANES-2:0] v_sr;
  logic [NUM_LANES-2:0] l_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_sr <= '0;
      l_sr <= '0;
    end else if (advance) begin
      v_sr[0] <= slot_valid;
      l_sr[0] <= slot_last;
      for (int k = 1; k < NUM_LANES - 1; k++) begin
        v_sr[k] <= v_sr[k-1];
        l_sr[k] <= l_sr[k-1];
      end
    end
  end

  // Per-lane sources for the output registers: lane i sees the slot issued i advances ago.
  logic [NUM_LANES-1:0] src_v;
  logic [VW-1:0]        src_d;

  assign src_v = {v_sr, slot_valid};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign src_d[0 +: DATA_WIDTH] = slot_data[0 +: DATA_WIDTH];
    end else begin : g_dly
      // Lane i only carries its own element through i delay stages.
      logic [DATA_WIDTH-1:0] d_sr [i];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < i; k++) d_sr[k] <= '0;
        end else if (advance) begin
          d_sr[0] <= slot_data[i*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < i; k++) d_sr[k] <= d_sr[k-1];
        end
      end
      assign src_d[i*DATA_WIDTH +: DATA_WIDTH] = d_sr[i-1];
    end
  end

  // Output registers. Data only updates on a valid element so a lane holds its
  // last operand through bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_ena  <= '0;
      out_last <= 1'b0;
    end else if (advance) begin
      out_ena  <= src_v;
      out_last <= src_v[NUM_LANES-1] && l_sr[NUM_LANES-2];
      for (int i = 0; i < NUM_LANES; i++) begin
        if (src_v[i]) out_data[i*DATA_WIDTH +: DATA_WIDTH] <= src_d[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      out_ena  <= '0;
      out_last <= 1'b0;
    end
  end

  // out_ena is included so busy stays high until the final lane has been presented.
  assign busy = (state != IDLE) || !fifo_empty || (|v_sr) || (|out_ena);

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Directed bench for pe_skew_feeder with hand-computed expectations (4 lanes x 16 bits, depth 4).
module tb_pe_skew_feeder;

  localparam int DW = 16;
  localparam int NL = 4;
  localparam int FD = 4;
  localparam int VW = NL * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_last;
  logic          stall;
  logic [VW-1:0] out_data;
  logic [NL-1:0] out_ena;
  logic          out_last;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_skew_feeder #(
    .DATA_WIDTH (DW),
    .NUM_LANES  (NL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .stall    (stall),
    .out_data (out_data),
    .out_ena  (out_ena),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    stall    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Vector with lane k = base + k.
  function automatic logic [VW-1:0] mk(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] t2_vec [4];
    logic [3:0]    t2_ena [13];
    logic [3:0]    tile;
    bit            mixed;
    bit            seen;
    logic [VW-1:0] held;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_out_ena", 64'(out_ena), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_last", 64'(out_last), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);

    // ---------------- single tile ----------------
    in_valid = 1'b1; in_data = mk(16'h0001); in_last = 1'b1;
    step();                                   // push
    in_valid = 1'b0; in_last = 1'b0;
    check("t1_busy_queued", 64'(busy), 64'h1);
    step();                                   // pop -> lane 0
    check("t1_ena_l0", 64'(out_ena), 64'h1);
    check("t1_data_l0", 64'(out_data), 64'h0000_0000_0000_0001);
    step();
    check("t1_ena_l1", 64'(out_ena), 64'h2);
    check("t1_data_l1", 64'(out_data), 64'h0000_0000_0002_0001);
    step();
    check("t1_ena_l2", 64'(out_ena), 64'h4);
    check("t1_data_l2", 64'(out_data), 64'h0000_0003_0002_0001);
    step();
    check("t1_ena_l3", 64'(out_ena), 64'h8);
    check("t1_last_l3", 64'(out_last), 64'h1);
    check("t1_data_l3", 64'(out_data), 64'h0004_0003_0002_0001);
    check("t1_busy_l3", 64'(busy), 64'h1);
    step();
    check("t1_ena_done", 64'(out_ena), 64'h0);
    check("t1_last_done", 64'(out_last), 64'h0);
    check("t1_busy_done", 64'(busy), 64'h0);
    check("t1_data_hold", 64'(out_data), 64'h0004_0003_0002_0001);

    // ---------------- back-to-back tiles ----------------
    // A pops on edges 2,3; three drain bubbles; B pops on edges 7,8.
    do_reset();
    t2_vec = '{mk(16'hA000), mk(16'hA010), mk(16'hB000), mk(16'hB010)};
    t2_ena = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8,
               4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0};
    for (int n = 1; n <= 12; n++) begin
      if (n <= 4) begin
        in_valid = 1'b1;
        in_data  = t2_vec[n-1];
        in_last  = (n == 2) || (n == 4);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      step();
      if (n >= 2) begin
        check($sformatf("t2_ena_c%0d", n), 64'(out_ena), 64'(t2_ena[n]));
        check($sformatf("t2_last_c%0d", n), 64'(out_last), 64'((n == 6) || (n == 11)));
        mixed = 1'b0;
        seen  = 1'b0;
        tile  = '0;
        for (int i = 0; i < NL; i++) begin
          if (out_ena[i]) begin
            if (seen && (out_data[i*DW+12 +: 4] != tile)) mixed = 1'b1;
            tile = out_data[i*DW+12 +: 4];
            seen = 1'b1;
          end
        end
        check($sformatf("t2_mixed_c%0d", n), 64'(mixed), 64'h0);
      end
      if (n == 6)  check("t2_data_a1", 64'(out_data), 64'(mk(16'hA010)));
      if (n == 7)  check("t2_lane0_b0", 64'(out_data[15:0]), 64'hB000);
      if (n == 11) check("t2_data_b1", 64'(out_data), 64'(mk(16'hB010)));
    end

    // ---------------- full FIFO ----------------
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = mk(16'(16'h3000 + 16 * k));
      in_last  = 1'b0;
      step();
      check($sformatf("t3_in_ready_p%0d", k), 64'(in_ready), 64'((k < 3) ? 1 : 0));
    end
    in_data = mk(16'h3040); in_last = 1'b1;      // 5th vector held while full
    step();
    check("t3_in_ready_held", 64'(in_ready), 64'h0);
    check("t3_ena_stalled", 64'(out_ena), 64'h0);
    stall = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 0) check("t3_in_ready_after_pop", 64'(in_ready), 64'h1);
      if (j == 1) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (j < 5) begin
        check($sformatf("t3_l0_ena_%0d", j), 64'(out_ena[0]), 64'h1);
        check($sformatf("t3_l0_data_%0d", j), 64'(out_data[15:0]), 64'(16'h3000 + 16 * j));
      end
      if (j == 5) check("t3_l0_no_extra", 64'(out_ena[0]), 64'h0);
      if (j >= 3) begin
        check($sformatf("t3_l3_data_%0d", j), 64'(out_data[63:48]), 64'(16'h3003 + 16 * (j - 3)));
      end
      check($sformatf("t3_last_%0d", j), 64'(out_last), 64'((j == 7) ? 1 : 0));
    end

    // ---------------- stall mid-skew ----------------
    do_reset();
    in_valid = 1'b1; in_data = mk(16'h4000); in_last = 1'b1;
    step();                                   // push
    in_valid = 1'b0; in_last = 1'b0;
    step();                                   // lane 0
    step();                                   // lane 1
    check("t4_ena_l1", 64'(out_ena), 64'h2);
    held = out_data;
    check("t4_data_l1", 64'(held), 64'h0000_0000_4001_4000);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("t4_stall_ena_%0d", s), 64'(out_ena), 64'h0);
      check($sformatf("t4_stall_data_%0d", s), 64'(out_data), 64'h0000_0000_4001_4000);
    end
    check("t4_stall_busy", 64'(busy), 64'h1);
    stall = 1'b0;
    step();
    check("t4_ena_l2", 64'(out_ena), 64'h4);
    check("t4_data_l2", 64'(out_data), 64'h0000_4002_4001_4000);
    step();
    check("t4_ena_l3", 64'(out_ena), 64'h8);
    check("t4_last_l3", 64'(out_last), 64'h1);
    check("t4_data_l3", 64'(out_data), 64'(mk(16'h4000)));
    step();
    check("t4_ena_done", 64'(out_ena), 64'h0);

    // ---------------- reset mid-tile ----------------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = mk(16'(16'h5000 + 16 * k));
      in_last  = 1'b0;
      stall    = (k == 3);
      step();
    end
    check("t5_busy_pre", 64'(busy), 64'h1);
    in_valid = 1'b0;
    stall    = 1'b0;
    rst      = 1'b1;
    step();
    check("t5_ena", 64'(out_ena), 64'h0);
    check("t5_data", 64'(out_data), 64'h0);
    check("t5_last", 64'(out_last), 64'h0);
    check("t5_busy", 64'(busy), 64'h0);
    check("t5_in_ready", 64'(in_ready), 64'h1);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("t5_post_ena_%0d", c), 64'(out_ena), 64'h0);
      check($sformatf("t5_post_busy_%0d", c), 64'(busy), 64'h0);
    end

    // ---------------- empty-FIFO bubble ----------------
    do_reset();
    in_valid = 1'b1; in_data = mk(16'h6000); in_last = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < NL; i++) begin
      step();
      check($sformatf("t6_ena_l%0d", i), 64'(out_ena), 64'(1 << i));
    end
    check("t6_data", 64'(out_data), 64'(mk(16'h6000)));
    check("t6_last", 64'(out_last), 64'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t6_bubble_ena_%0d", c), 64'(out_ena), 64'h0);
      // FSM remains in STREAM with no tile end seen, which keeps busy high.
      check($sformatf("t6_busy_stream_%0d", c), 64'(busy), 64'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
